booth_ctrl: RTL and testbench

Control sequencer for the radix-2 Booth multiplier datapath. It accepts a multiply request through a start handshake and drives the datapath's load, add/sub and shift strobes from the datapath's `Q_LSB` feedback. It counts the N iterations and presents a done handshake while the product is valid on the datapath's `Y`. It sits between the requesting logic and the Booth datapath, and owns all sequencing; the datapath holds no state machine.

---
 rtl/booth_pkg.sv | 24 ++
 rtl/booth_ctrl.sv | 144 ++++++++++++++
 tb/tb_booth_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier controller.
// State encoding, Q_LSB feedback codes and add_sub polarity.
package booth_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } booth_state_t;

    // Datapath feedback {LQ[0], Q_1}
    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

    // add_sub strobe polarity
    localparam logic ADD_SUB_ADD = 1'b1;
    localparam logic ADD_SUB_SUB = 1'b0;

endpackage

// File: rtl/booth_ctrl.sv
// Sequencer for the radix-2 Booth multiplier datapath.
// Accepts a request in IDLE, loads operands, walks N Booth iterations
// (optional add/sub followed by an arithmetic shift) and holds done until
// acknowledged.
// Optional feature: define BOOTH_CTRL_STATS_EN to add the op_count output,
// which counts add/sub cycles of the current or most recent product.
// Handshakes: start is taken when start && start_ready (IDLE only);
// done is held high until the cycle in which done_ack is seen.
module booth_ctrl
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       start_ready,
    input  logic [1:0]                 Q_LSB,
    output logic                       load_A,
    output logic                       load_B,
    output logic                       load_add,
    output logic                       add_sub,
    output logic                       shift_HQ_LQ_Q_1,
    output logic                       done,
    input  logic                       done_ack,
`ifdef BOOTH_CTRL_STATS_EN
    output logic [$clog2(N+1)-1:0]     op_count,
`endif
    output booth_state_t               dbg_state_o
);

    localparam int CW = $clog2(N + 1);

    booth_state_t    state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_shift;

`ifdef BOOTH_CTRL_STATS_EN
    logic [CW-1:0]   op_cnt_q, op_cnt_d;
`endif

    // State, iteration counter and optional statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
`ifdef BOOTH_CTRL_STATS_EN
            op_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
`ifdef BOOTH_CTRL_STATS_EN
            op_cnt_q <= op_cnt_d;
`endif
        end
    end

    // Next-state and strobe decode from the current state and Q_LSB
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        start_ready     = 1'b0;
        load_A          = 1'b0;
        load_B          = 1'b0;
        load_add        = 1'b0;
        add_sub         = 1'b0;
        shift_HQ_LQ_Q_1 = 1'b0;
        done            = 1'b0;
        do_shift        = 1'b0;
`ifdef BOOTH_CTRL_STATS_EN
        op_cnt_d        = op_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_A  = 1'b1;
                load_B  = 1'b1;
                cnt_d   = CW'(N);
                state_d = ST_EVAL;
`ifdef BOOTH_CTRL_STATS_EN
                op_cnt_d = '0;
`endif
            end
            ST_EVAL: begin
                case (Q_LSB)
                    BOOTH_ADD: begin
                        load_add = 1'b1;
                        add_sub  = ADD_SUB_ADD;
                        state_d  = ST_SHIFT;
                    end
                    BOOTH_SUB: begin
                        load_add = 1'b1;
                        add_sub  = ADD_SUB_SUB;
                        state_d  = ST_SHIFT;
                    end
                    BOOTH_NOP0: do_shift = 1'b1;
                    BOOTH_NOP1: do_shift = 1'b1;
                endcase
            end
            ST_SHIFT: begin
                do_shift = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                // An ack wins over a simultaneous start; the requester retries
                if (done_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Shift cycle: one Booth iteration completes here
        if (do_shift) begin
            shift_HQ_LQ_Q_1 = 1'b1;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
            state_d = (cnt_q <= CW'(1)) ? ST_DONE : ST_EVAL;
        end

`ifdef BOOTH_CTRL_STATS_EN
        if (load_add) begin
            op_cnt_d = op_cnt_q + CW'(1);
        end
`endif
    end

`ifdef BOOTH_CTRL_STATS_EN
    assign op_count = op_cnt_q;
`endif

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl with N=8. A behavioural Booth datapath
// closes the Q_LSB loop; the expected per-cycle strobe trace is derived
// from Booth recoding of the multiplier bits and checked every cycle.
module tb_booth_ctrl;
  import booth_pkg::*;

  localparam int N = 8;
  localparam int CW = $clog2(N + 1);

  // {start_ready, load_A, load_B, load_add, add_sub, shift, done}
  localparam logic [6:0] V_IDLE = 7'b1000000;
  localparam logic [6:0] V_LOAD = 7'b0110000;
  localparam logic [6:0] V_ADD  = 7'b0001100;
  localparam logic [6:0] V_SUB  = 7'b0001000;
  localparam logic [6:0] V_SHF  = 7'b0000010;
  localparam logic [6:0] V_DONE = 7'b0000001;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic start_ready;
  logic [1:0] q_lsb;
  logic load_a, load_b, load_add, add_sub, shift_s, done, done_ack;
  booth_state_t dbg_state;
`ifdef BOOTH_CTRL_STATS_EN
  logic [CW-1:0] op_count;
`endif

  int checks = 0;
  int failures = 0;
  logic [6:0] exp_q[$];
  logic [6:0] tr[$];
  logic [6:0] cmp_e;

  // behavioural datapath state
  logic [7:0] a_in = '0, b_in = '0;
  logic [7:0] m = '0, hq = '0, lq = '0;
  logic q1 = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  booth_ctrl #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .start_ready(start_ready),
    .Q_LSB(q_lsb),
    .load_A(load_a),
    .load_B(load_b),
    .load_add(load_add),
    .add_sub(add_sub),
    .shift_HQ_LQ_Q_1(shift_s),
    .done(done),
    .done_ack(done_ack),
`ifdef BOOTH_CTRL_STATS_EN
    .op_count(op_count),
`endif
    .dbg_state_o(dbg_state)
  );

  wire [6:0] act = {start_ready, load_a, load_b, load_add, add_sub, shift_s, done};
  assign q_lsb = {lq[0], q1};

  // Booth datapath model driven by the controller strobes
  always @(posedge clk) begin
    if (load_a) m <= a_in;
    if (load_b) begin
      lq <= b_in;
      hq <= '0;
      q1 <= 1'b0;
    end
    if (load_add) hq <= add_sub ? hq + m : hq - m;
    else if (shift_s) {hq, lq, q1} <= {hq[7], hq, lq};
  end

  // scoreboard: one expected strobe vector per queued cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      checks++;
      if (act !== cmp_e) begin
        failures++;
        $display("FAIL strobes t=%0t got=%b exp=%b", $time, act, cmp_e);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  // Expected trace from Booth recoding: each bit that differs from the
  // bit below it costs an add/sub cycle before its shift.
  task automatic build_trace(input logic [7:0] b, input int hold);
    logic prev;
    tr.delete();
    tr.push_back(V_IDLE);
    tr.push_back(V_LOAD);
    prev = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (b[i] != prev) tr.push_back(b[i] ? V_SUB : V_ADD);
      tr.push_back(V_SHF);
      prev = b[i];
    end
    for (int i = 0; i < hold; i++) tr.push_back(V_DONE);
    tr.push_back(V_IDLE);
  endtask

  // driver: one multiplication, optional stray starts, optional reset
  task automatic run(input logic [7:0] a, input logic [7:0] b, input int hold,
                     input int lat, input logic [15:0] y_exp, input int k_exp,
                     input bit pulse, input int rst_at);
    int first_done;
    int last;
    first_done = -1;
    a_in = a;
    b_in = b;
    build_trace(b, hold);
    last = tr.size();
    for (int c = 0; c < last; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) start = 1'b1;
      else start = pulse && (c == 2 || c == last - 2);
      done_ack = (c == last - 2);
      if (rst_at > 0 && c == rst_at) begin
        rst = 1'b1;
        start = 1'b0;
        done_ack = 1'b0;
        exp_q.push_back(V_IDLE);
        @(negedge clk);
`ifdef BOOTH_CTRL_STATS_EN
        chk("op_count_rst", int'(op_count), 0);
`endif
        break;
      end
      exp_q.push_back(tr[c]);
      @(negedge clk);
      if (tr[c] == V_DONE) chk("y_stable", int'({hq, lq}), int'(y_exp));
      if (done && first_done < 0) begin
        first_done = c;
`ifdef BOOTH_CTRL_STATS_EN
        chk("op_count", int'(op_count), k_exp);
`endif
      end
    end
    if (rst_at == 0) chk("done_latency", first_done, lat);
    @(posedge clk);
    #1;
    start = 1'b0;
    done_ack = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    done_ack = 1'b0;
    #1;
    exp_q.push_back(V_IDLE);
    @(negedge clk);
`ifdef BOOTH_CTRL_STATS_EN
    chk("op_count_reset", int'(op_count), 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    //  a      b      hold lat  y          k  pulse rst_at
    run(8'd3, 8'd5,   2,   14,  16'd15,    4, 1'b0, 0);
    run(8'd7, 8'd0,   2,   10,  16'd0,     0, 1'b0, 0);
    run(8'd2, 8'hFF,  2,   11,  16'hFFFE,  1, 1'b0, 0);
    run(8'd1, 8'h55,  2,   18,  16'd85,    8, 1'b0, 0);
    run(8'd3, 8'd5,   6,   14,  16'd15,    4, 1'b1, 0);
    run(8'd3, 8'd5,   2,   14,  16'd15,    4, 1'b0, 6);
    run(8'd3, 8'd5,   2,   14,  16'd15,    4, 1'b0, 0);

    repeat (2) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
